// File: rtl/lc3_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// lc3_pipe_ctrl
//   Pipeline controller for a four-stage LC-3 core (fetch, decode, execute,
//   writeback). It produces the per-stage enables and sequences data-memory
//   accesses through a small registered FSM that has a timeout. It holds
//   fetch while a BR/JMP is in flight and generates operand bypass selects
//   for the instruction in decode.
//
// Parameters
//   TIMEOUT_CYC  cycles allowed in any non-idle memory state before abort (>=2)
//   FWD_EN       1: bypass selects active, 0: bypass selects tied low
//   BR_EXTRA     extra fetch-hold cycles after a control instruction (0..7)
//
// Ports
//   clk              clock
//   rst              asynchronous active-low reset
//   imem_dout_i      instruction currently being fetched
//   ir_dec_i         instruction in decode
//   ir_exec_i        instruction in execute
//   nzp_i            BR condition bits of ir_exec_i
//   psr_i            current N/Z/P flags
//   dmem_complete_i  one-cycle pulse: data memory finished the current access
//   en_updatepc_o    PC update enable
//   en_fetch_o       fetch enable
//   en_decode_o      decode enable
//   en_execute_o     execute enable
//   en_writeback_o   register-file write enable
//   br_taken_o       redirect PC (one cycle)
//   byp_alu_1_o/2_o  src1/src2 take the execute ALU result
//   byp_mem_1_o/2_o  src1/src2 take the memory/LEA result
//   mem_state_o      0 READ, 1 IND, 2 WRITE, 3 IDLE
//   mem_err_o        one-cycle pulse after an access timed out
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module lc3_pipe_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter bit          FWD_EN      = 1'b1,
  parameter int unsigned BR_EXTRA    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] imem_dout_i,
  input  logic [15:0] ir_dec_i,
  input  logic [15:0] ir_exec_i,
  input  logic [2:0]  nzp_i,
  input  logic [2:0]  psr_i,
  input  logic        dmem_complete_i,
  output logic        en_updatepc_o,
  output logic        en_fetch_o,
  output logic        en_decode_o,
  output logic        en_execute_o,
  output logic        en_writeback_o,
  output logic        br_taken_o,
  output logic        byp_alu_1_o,
  output logic        byp_alu_2_o,
  output logic        byp_mem_1_o,
  output logic        byp_mem_2_o,
  output logic [1:0]  mem_state_o,
  output logic        mem_err_o
);

  localparam int unsigned     CNT_W     = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]       HOLD_INIT = 3'(BR_EXTRA);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    MS_READ  = 2'd0,
    MS_IND   = 2'd1,
    MS_WRITE = 2'd2,
    MS_IDLE  = 2'd3
  } mem_state_e;

  // ---------------- opcode class helpers ----------------
  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

  function automatic logic is_ldc(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_memop(input logic [3:0] op);
    return is_ldc(op) || (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  function automatic logic is_writes(input logic [3:0] op);
    return is_alu(op) || is_ldc(op) || (op == OP_LEA);
  endfunction

  function automatic logic is_ctrl(input logic [3:0] op);
    return (op == OP_BR) || (op == OP_JMP);
  endfunction

  // ---------------- state ----------------
  logic        v_dec_q, v_dec_d;
  logic        v_exe_q, v_exe_d;
  logic        v_wb_q, v_wb_d;
  logic        ctrl_pend_q, ctrl_pend_d;
  logic [2:0]  hold_q, hold_d;
  mem_state_e  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic        mem_err_q;

  logic [3:0]  exe_op_s, dec_op_s, fetch_op_s;
  logic [2:0]  dest_s;
  logic        complete_rw_s, tmo_s, stall_s, fetch_s, ctrl_exe_s, byp_gate_s;
  logic        unused_bits_s;

  assign exe_op_s   = ir_exec_i[15:12];
  assign dec_op_s   = ir_dec_i[15:12];
  assign fetch_op_s = imem_dout_i[15:12];
  assign dest_s     = ir_exec_i[11:9];

  assign unused_bits_s = ^{imem_dout_i[11:0], ir_dec_i[4:3], ir_exec_i[8:0]};

  // Completion only counts in the states that finish an access; in IND it
  // advances the FSM but the data access is still outstanding.
  assign complete_rw_s = dmem_complete_i && ((state_q == MS_READ) || (state_q == MS_WRITE));
  // A completion arriving on the last allowed cycle beats the timeout.
  assign tmo_s   = (state_q != MS_IDLE) && (cnt_q == CNT_LAST) && !dmem_complete_i;
  assign stall_s = v_exe_q && is_memop(exe_op_s) && !complete_rw_s && !tmo_s;
  // rst gates fetch so the enables drop the moment reset is asserted.
  assign fetch_s = rst && !stall_s && !ctrl_pend_q && (hold_q == 3'd0);
  assign ctrl_exe_s = v_exe_q && is_ctrl(exe_op_s);
  assign byp_gate_s = FWD_EN && v_dec_q && v_exe_q && is_writes(exe_op_s);

  assign en_updatepc_o  = fetch_s;
  assign en_fetch_o     = fetch_s;
  assign en_decode_o    = v_dec_q && !stall_s;
  assign en_execute_o   = v_exe_q;
  assign en_writeback_o = v_wb_q;
  assign br_taken_o     = ctrl_exe_s && ((exe_op_s == OP_JMP) || (|(nzp_i & psr_i)));
  assign mem_state_o    = state_q;
  assign mem_err_o      = mem_err_q;

  // Next-state for valid flags, control-pending flag and hold counter
  always_comb begin
    v_dec_d     = v_dec_q;
    v_exe_d     = v_exe_q;
    ctrl_pend_d = ctrl_pend_q;
    hold_d      = hold_q;
    if (stall_s) begin
      v_dec_d = v_dec_q;
      v_exe_d = v_exe_q;
    end else begin
      v_dec_d = fetch_s;
      v_exe_d = v_dec_q;
    end
    v_wb_d = !stall_s && v_exe_q && is_writes(exe_op_s) && !tmo_s;
    // A new control fetch wins over a control instruction leaving execute.
    if (fetch_s && is_ctrl(fetch_op_s)) begin
      ctrl_pend_d = 1'b1;
    end else if (ctrl_exe_s) begin
      ctrl_pend_d = 1'b0;
    end else begin
      ctrl_pend_d = ctrl_pend_q;
    end
    if (ctrl_exe_s) begin
      hold_d = HOLD_INIT;
    end else if (hold_q != 3'd0) begin
      hold_d = hold_q - 3'd1;
    end else begin
      hold_d = hold_q;
    end
  end

  // Pipeline valid / control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_dec_q     <= 1'b0;
      v_exe_q     <= 1'b0;
      v_wb_q      <= 1'b0;
      ctrl_pend_q <= 1'b0;
      hold_q      <= 3'd0;
    end else begin
      v_dec_q     <= v_dec_d;
      v_exe_q     <= v_exe_d;
      v_wb_q      <= v_wb_d;
      ctrl_pend_q <= ctrl_pend_d;
      hold_q      <= hold_d;
    end
  end

  // Data-memory access FSM with per-state timeout counter and error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MS_IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= tmo_s;
      case (state_q)
        MS_IDLE: begin
          cnt_q <= '0;
          if (v_exe_q && ((exe_op_s == OP_LD) || (exe_op_s == OP_LDR))) begin
            state_q <= MS_READ;
          end else if (v_exe_q && ((exe_op_s == OP_ST) || (exe_op_s == OP_STR))) begin
            state_q <= MS_WRITE;
          end else if (v_exe_q && ((exe_op_s == OP_LDI) || (exe_op_s == OP_STI))) begin
            state_q <= MS_IND;
          end else begin
            state_q <= MS_IDLE;
          end
        end
        MS_IND: begin
          if (dmem_complete_i) begin
            state_q <= (exe_op_s == OP_STI) ? MS_WRITE : MS_READ;
            cnt_q   <= '0;
          end else if (tmo_s) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        MS_READ, MS_WRITE: begin
          if (dmem_complete_i || tmo_s) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= MS_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Bypass selects for the decode-stage source operands
  always_comb begin
    logic       src1_use, src2_use;
    logic [2:0] src2_reg;
    byp_alu_1_o = 1'b0;
    byp_alu_2_o = 1'b0;
    byp_mem_1_o = 1'b0;
    byp_mem_2_o = 1'b0;
    src1_use = is_alu(dec_op_s) || (dec_op_s == OP_LDR) ||
               (dec_op_s == OP_STR) || (dec_op_s == OP_JMP);
    src2_use = 1'b0;
    src2_reg = 3'd0;
    // Register-mode ADD/AND read SR2; stores read the data register in [11:9].
    if (((dec_op_s == OP_ADD) || (dec_op_s == OP_AND)) && !ir_dec_i[5]) begin
      src2_use = 1'b1;
      src2_reg = ir_dec_i[2:0];
    end else if ((dec_op_s == OP_ST) || (dec_op_s == OP_STI) || (dec_op_s == OP_STR)) begin
      src2_use = 1'b1;
      src2_reg = ir_dec_i[11:9];
    end else begin
      src2_use = 1'b0;
      src2_reg = 3'd0;
    end
    if (byp_gate_s) begin
      if (src1_use && (ir_dec_i[8:6] == dest_s)) begin
        byp_alu_1_o = is_alu(exe_op_s);
        byp_mem_1_o = is_ldc(exe_op_s) || (exe_op_s == OP_LEA);
      end else begin
        byp_alu_1_o = 1'b0;
        byp_mem_1_o = 1'b0;
      end
      if (src2_use && (src2_reg == dest_s)) begin
        byp_alu_2_o = is_alu(exe_op_s);
        byp_mem_2_o = is_ldc(exe_op_s) || (exe_op_s == OP_LEA);
      end else begin
        byp_alu_2_o = 1'b0;
        byp_mem_2_o = 1'b0;
      end
    end else begin
      byp_alu_1_o = 1'b0;
      byp_alu_2_o = 1'b0;
      byp_mem_1_o = 1'b0;
      byp_mem_2_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
`timescale 1ns/1ps
module tb_lc3_pipe_ctrl;

  localparam logic [15:0] FILL = 16'hD000;  // reserved opcode: no class at all

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_dout, ir_dec, ir_exec;
  logic [2:0]  nzp, psr;
  logic        dmem_complete;

  logic en_updatepc, en_fetch, en_decode, en_execute, en_writeback, br_taken;
  logic byp_alu_1, byp_alu_2, byp_mem_1, byp_mem_2, mem_err;
  logic [1:0] mem_state;

  logic z_alu_1, z_alu_2, z_mem_1, z_mem_2;
  logic [6:0] z_unused_misc;
  logic [1:0] z_unused_ms;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lc3_pipe_ctrl #(.TIMEOUT_CYC(16), .FWD_EN(1'b1), .BR_EXTRA(2)) dut (
    .clk(clk), .rst(rst), .imem_dout_i(imem_dout), .ir_dec_i(ir_dec), .ir_exec_i(ir_exec),
    .nzp_i(nzp), .psr_i(psr), .dmem_complete_i(dmem_complete),
    .en_updatepc_o(en_updatepc), .en_fetch_o(en_fetch), .en_decode_o(en_decode),
    .en_execute_o(en_execute), .en_writeback_o(en_writeback), .br_taken_o(br_taken),
    .byp_alu_1_o(byp_alu_1), .byp_alu_2_o(byp_alu_2), .byp_mem_1_o(byp_mem_1),
    .byp_mem_2_o(byp_mem_2), .mem_state_o(mem_state), .mem_err_o(mem_err));

  lc3_pipe_ctrl #(.TIMEOUT_CYC(16), .FWD_EN(1'b0), .BR_EXTRA(2)) dut0 (
    .clk(clk), .rst(rst), .imem_dout_i(imem_dout), .ir_dec_i(ir_dec), .ir_exec_i(ir_exec),
    .nzp_i(nzp), .psr_i(psr), .dmem_complete_i(dmem_complete),
    .en_updatepc_o(z_unused_misc[0]), .en_fetch_o(z_unused_misc[1]), .en_decode_o(z_unused_misc[2]),
    .en_execute_o(z_unused_misc[3]), .en_writeback_o(z_unused_misc[4]), .br_taken_o(z_unused_misc[5]),
    .byp_alu_1_o(z_alu_1), .byp_alu_2_o(z_alu_2), .byp_mem_1_o(z_mem_1),
    .byp_mem_2_o(z_mem_2), .mem_state_o(z_unused_ms), .mem_err_o(z_unused_misc[6]));

  typedef struct {
    logic [15:0] dec;
    logic [15:0] exe;
    logic [2:0]  nzp;
    logic [2:0]  psr;
    logic [5:0]  exp;   // {alu1, alu2, mem1, mem2, en_fetch, br_taken}
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fillers();
    imem_dout = FILL; ir_dec = FILL; ir_exec = FILL;
    nzp = 3'b000; psr = 3'b000; dmem_complete = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ldi_ms [9];
    logic       ldi_fe [9];
    logic       ldi_wb [9];
    logic       br_fe  [6];
    logic       br_br  [6];

    vt[0]  = '{16'h1841, 16'h1283, 3'b000, 3'b000, 6'b110010}; // ADD after ADD R1
    vt[1]  = '{16'h7240, 16'h2205, 3'b000, 3'b000, 6'b001100}; // STR after LD R1
    vt[2]  = '{16'h1461, 16'h1283, 3'b000, 3'b000, 6'b100010}; // ADD imm: no src2
    vt[3]  = '{16'h967F, 16'hE200, 3'b000, 3'b000, 6'b001010}; // NOT after LEA
    vt[4]  = '{16'h3200, 16'h5283, 3'b000, 3'b000, 6'b010010}; // ST data from AND
    vt[5]  = '{16'hC040, 16'h1283, 3'b000, 3'b000, 6'b100010}; // JMP base from ADD
    vt[6]  = '{16'h1841, 16'h3200, 3'b000, 3'b000, 6'b000000}; // ST in exec: no bypass
    vt[7]  = '{16'h1841, 16'h1483, 3'b000, 3'b000, 6'b000010}; // dest mismatch
    vt[8]  = '{16'h2205, 16'h1283, 3'b000, 3'b000, 6'b000010}; // LD in decode: none
    vt[9]  = '{FILL,     16'h0403, 3'b010, 3'b010, 6'b000011}; // BRz taken
    vt[10] = '{FILL,     16'h0403, 3'b010, 3'b100, 6'b000010}; // BRz not taken
    vt[11] = '{FILL,     16'hC1C0, 3'b000, 3'b000, 6'b000011}; // JMP always taken
    vt[12] = '{16'hB200, 16'h6280, 3'b000, 3'b000, 6'b000100}; // STI data from LDR
    vt[13] = '{16'h7240, 16'hA200, 3'b000, 3'b000, 6'b001100}; // STR after LDI

    ldi_ms = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3};
    ldi_fe = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ldi_wb = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    br_fe  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    br_br  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // ---- reset ----
    fillers();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 16'({en_updatepc, en_fetch, en_decode, en_execute, en_writeback, br_taken,
                         byp_alu_1, byp_alu_2, byp_mem_1, byp_mem_2, mem_err}), 16'd0);
    chk("rst_state", 16'(mem_state), 16'd3);
    next_cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("first_fetch", 16'({en_updatepc, en_fetch, en_decode}), 16'b110);
    repeat (3) next_cyc();

    // ---- table-driven combinational vectors (applied in the low phase only) ----
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ir_dec = vt[i].dec; ir_exec = vt[i].exe; nzp = vt[i].nzp; psr = vt[i].psr;
      #1;
      chk($sformatf("vec%0d_main", i),
          16'({byp_alu_1, byp_alu_2, byp_mem_1, byp_mem_2, en_fetch, br_taken}), 16'(vt[i].exp));
      chk($sformatf("vec%0d_nofwd", i), 16'({z_alu_1, z_alu_2, z_mem_1, z_mem_2}), 16'd0);
      #1;
      fillers();
    end

    // ---- LDI with completes at cycles 3 and 6 ----
    next_cyc();
    for (int c = 0; c < 9; c++) begin
      ir_exec = (c <= 6) ? 16'hAA02 : FILL;
      dmem_complete = (c == 3) || (c == 6);
      @(negedge clk);
      chk($sformatf("ldi_state%0d", c), 16'(mem_state), 16'(ldi_ms[c]));
      chk($sformatf("ldi_fetch%0d", c), 16'(en_fetch), 16'(ldi_fe[c]));
      chk($sformatf("ldi_wb%0d", c), 16'(en_writeback), 16'(ldi_wb[c]));
      next_cyc();
    end
    fillers();

    // ---- LD timeout: 16 READ cycles then error pulse ----
    for (int c = 0; c < 19; c++) begin
      ir_exec = (c <= 16) ? 16'h2205 : FILL;
      @(negedge clk);
      chk($sformatf("tmo_state%0d", c), 16'(mem_state),
          ((c >= 1) && (c <= 16)) ? 16'd0 : 16'd3);
      chk($sformatf("tmo_err%0d", c), 16'(mem_err), (c == 17) ? 16'd1 : 16'd0);
      chk($sformatf("tmo_wb%0d", c), 16'(en_writeback), 16'd0);
      chk($sformatf("tmo_fetch%0d", c), 16'(en_fetch), (c >= 16) ? 16'd1 : 16'd0);
      next_cyc();
    end

    // ---- complete on the would-be timeout cycle: no error, writeback ----
    for (int c = 0; c < 18; c++) begin
      ir_exec = (c <= 16) ? 16'h2205 : FILL;
      dmem_complete = (c == 16);
      @(negedge clk);
      if (c == 16) begin
        chk("race_state16", 16'({mem_state, en_fetch}), 16'b001);
      end
      if (c == 17) begin
        chk("race_state17", 16'(mem_state), 16'd3);
        chk("race_err17", 16'(mem_err), 16'd0);
        chk("race_wb17", 16'(en_writeback), 16'd1);
      end
      next_cyc();
    end
    fillers();

    // ---- BRz taken with BR_EXTRA=2 ----
    for (int c = 0; c < 6; c++) begin
      imem_dout = (c == 0) ? 16'h0403 : FILL;
      ir_dec    = (c == 1) ? 16'h0403 : FILL;
      ir_exec   = (c == 2) ? 16'h0403 : FILL;
      nzp       = (c == 2) ? 3'b010 : 3'b000;
      psr       = 3'b010;
      @(negedge clk);
      chk($sformatf("br_fetch%0d", c), 16'({en_updatepc, en_fetch}), br_fe[c] ? 16'b11 : 16'b00);
      chk($sformatf("br_taken%0d", c), 16'(br_taken), 16'(br_br[c]));
      next_cyc();
    end
    fillers();
    repeat (3) next_cyc();

    // ---- reset asserted mid-WRITE ----
    ir_exec = 16'h3200;
    @(negedge clk);
    chk("rw_idle", 16'(mem_state), 16'd3);
    next_cyc();
    @(negedge clk);
    chk("rw_write", 16'({mem_state, en_execute}), 16'b101);
    #1 rst = 1'b0;
    #1;
    chk("rw_state_now", 16'(mem_state), 16'd3);
    chk("rw_enables_now", 16'({en_updatepc, en_fetch, en_decode, en_execute, en_writeback,
                               br_taken, mem_err}), 16'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rw_err_held", 16'({mem_err, en_writeback}), 16'd0);
    end
    next_cyc();
    rst = 1'b1;
    fillers();
    @(negedge clk);
    chk("rw_restart", 16'({en_updatepc, en_fetch, mem_err, mem_state}), 16'b11011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
